// File: rtl/pwm_cap_pkg.sv
// Shared types and constants for the PWM duty-capture block.
// The PWM_CAP_FILTER_EN build option is consumed by pwm_in_sync and pwm_duty_capture.
package pwm_cap_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } cap_state_e;

    function automatic logic [31:0] all_ones(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// Synchronizes the asynchronous PWM input and produces a clean level plus registered edge strobes.
// With PWM_CAP_FILTER_EN defined, a new level is accepted only after FILT_LEN equal samples.
module pwm_in_sync
`ifdef PWM_CAP_FILTER_EN
    #(parameter int FILT_LEN = 4)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;
    logic lvl_in;

`ifdef PWM_CAP_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);
    logic          flt_lvl;
    logic [FW-1:0] flt_run;

    // Run length counts consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flt_lvl <= 1'b0;
            flt_run <= '0;
        end else if (s2 == flt_lvl) begin
            flt_run <= '0;
        end else if (flt_run == FW'(FILT_LEN - 1)) begin
            flt_lvl <= s2;
            flt_run <= '0;
        end else begin
            flt_run <= flt_run + 1'b1;
        end
    end

    assign lvl_in = flt_lvl;
`else
    assign lvl_in = s2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= pwm_in;
            s2   <= s1;
            s3   <= lvl_in;
            rise <= lvl_in & ~s3;
            fall <= ~lvl_in & s3;
        end
    end

    // level is aligned with the strobes: it already shows the post-edge value.
    assign level = s3;

endmodule

// File: rtl/pwm_duty_capture.sv
// Measures high time and period of one PWM input in clk cycles and reports stuck levels by timeout.
// Optional input glitch filter is compiled in with PWM_CAP_FILTER_EN.
module pwm_duty_capture
    import pwm_cap_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = 65535
`ifdef PWM_CAP_FILTER_EN
    , parameter int FILT_LEN = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             stuck_hi,
    output logic             stuck_lo
);

    localparam logic [CNT_W-1:0] ONES    = CNT_W'(all_ones(CNT_W));
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic             level, rise, fall;
    cap_state_e       state;
    logic [CNT_W-1:0] cnt, hi_len, idle_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout;

`ifdef PWM_CAP_FILTER_EN
    pwm_in_sync #(.FILT_LEN(FILT_LEN)) u_sync (
`else
    pwm_in_sync u_sync (
`endif
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    assign cnt_inc = (cnt == ONES) ? cnt : cnt + 1'b1;
    // An edge in the same cycle always beats the timeout.
    assign timeout = !rise && !fall && (idle_cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            hi_len     <= '0;
            idle_cnt   <= '0;
            high_cnt   <= '0;
            period_cnt <= '0;
            meas_valid <= 1'b0;
            stuck_hi   <= 1'b0;
            stuck_lo   <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!en) begin
                state    <= IDLE;
                cnt      <= '0;
                hi_len   <= '0;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= (rise || fall || timeout) ? '0 : idle_cnt + 1'b1;
                if (timeout) begin
                    state      <= IDLE;
                    cnt        <= '0;
                    hi_len     <= '0;
                    meas_valid <= 1'b1;
                    high_cnt   <= level ? ONES : '0;
                    period_cnt <= ONES;
                    stuck_hi   <= level;
                    stuck_lo   <= ~level;
                end else begin
                    case (state)
                        IDLE: begin
                            cnt    <= '0;
                            hi_len <= '0;
                            if (rise) begin
                                state <= HIGH;
                                cnt   <= CNT_W'(1);
                            end
                        end
                        HIGH: begin
                            cnt <= cnt_inc;
                            if (fall) begin
                                state  <= LOW;
                                hi_len <= cnt;
                            end
                        end
                        LOW: begin
                            if (rise) begin
                                high_cnt   <= hi_len;
                                period_cnt <= cnt;
                                meas_valid <= 1'b1;
                                stuck_hi   <= 1'b0;
                                stuck_lo   <= 1'b0;
                                state      <= HIGH;
                                cnt        <= CNT_W'(1);
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Randomized bench for pwm_duty_capture: a timestamp-based model predicts every published result.
// Also covers latency, stuck-level repeat interval, enable drop and asynchronous reset.
module tb_pwm_duty_capture;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 100;
    localparam int W       = 2 * CNT_W + 2;
    localparam logic [CNT_W-1:0] ONES = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
`ifdef PWM_CAP_FILTER_EN
    localparam int FILT_LEN = 4;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] high_cnt, period_cnt;
    logic             meas_valid, stuck_hi, stuck_lo;

    pwm_duty_capture #(
        .CNT_W   (CNT_W),
`ifdef PWM_CAP_FILTER_EN
        .FILT_LEN(FILT_LEN),
`endif
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pwm_in     (pwm_in),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .meas_valid (meas_valid),
        .stuck_hi   (stuck_hi),
        .stuck_lo   (stuck_lo)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Entry layout: {stuck_hi, stuck_lo, high, period}
    logic [W-1:0] exp_q[$];
    int unsigned  now, t_rise, t_fall, idle;
    bit           armed, fell, lvl;
`ifdef PWM_CAP_FILTER_EN
    bit           f_lvl;
    int           f_run;
`endif

    function automatic void model_clear(input bit full);
        armed = 0;
        fell  = 0;
        idle  = 0;
        if (full) begin
            lvl = 0;
            exp_q.delete();
`ifdef PWM_CAP_FILTER_EN
            f_lvl = 0;
            f_run = 0;
`endif
        end
    endfunction

    function automatic void model_step(input logic v);
        bit nl;
        nl = v;
`ifdef PWM_CAP_FILTER_EN
        if (v == f_lvl) f_run = 0;
        else begin
            f_run++;
            if (f_run == FILT_LEN) begin
                f_lvl = v;
                f_run = 0;
            end
        end
        nl = f_lvl;
`endif
        now++;
        if (nl && !lvl) begin
            if (armed && fell)
                exp_q.push_back({2'b00, CNT_W'(t_fall - t_rise), CNT_W'(now - t_rise)});
            armed  = 1;
            fell   = 0;
            t_rise = now;
            idle   = 0;
        end else if (!nl && lvl) begin
            if (armed) begin
                fell   = 1;
                t_fall = now;
            end
            idle = 0;
        end else begin
            idle++;
            if (idle == TIMEOUT) begin
                exp_q.push_back({nl, !nl, (nl ? ONES : ZERO), ONES});
                idle  = 0;
                armed = 0;
                fell  = 0;
            end
        end
        lvl = nl;
    endfunction

    // ---------------- scoreboard monitor ----------------
    int mv_count = 0;
    int mv_last  = -1;
    int mv_prev  = -1;
    int first_mv = -1;

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (meas_valid && !rst) begin
            mv_count++;
            mv_prev = mv_last;
            mv_last = cyc;
            if (first_mv < 0) first_mv = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("high_cnt",   32'(high_cnt),   32'(e[2*CNT_W-1:CNT_W]));
                check("period_cnt", 32'(period_cnt), 32'(e[CNT_W-1:0]));
                check("stuck_hi",   32'(stuck_hi),   32'(e[W-1]));
                check("stuck_lo",   32'(stuck_lo),   32'(e[W-2]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v);
        @(negedge clk);
        pwm_in = v;
        model_step(v);
    endtask

    task automatic hold(input int n);
        repeat (n) drive(pwm_in);
    endtask

    task automatic run_wave(input int h, input int p, input int n);
        repeat (n) begin
            repeat (h) drive(1'b1);
            repeat (p - h) drive(1'b0);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_high"},   32'(high_cnt),   32'd0);
        check({tag, "_period"}, 32'(period_cnt), 32'd0);
        check({tag, "_valid"},  32'(meas_valid), 32'd0);
        check({tag, "_shi"},    32'(stuck_hi),   32'd0);
        check({tag, "_slo"},    32'(stuck_lo),   32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rise2_cyc;
        int mv_snap;
        int p, h;

        now = 0;
        model_clear(1'b1);
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");

        rst = 1'b0;
        en  = 1'b1;
        model_clear(1'b1);
        hold(5);

        // Steady 3/10 and latency of the first published result
        run_wave(3, 10, 1);
        drive(1'b1);
        rise2_cyc = cyc;
        drive(1'b1);
        drive(1'b1);
        repeat (7) drive(1'b0);
        run_wave(3, 10, 4);
        check("first_latency", 32'(first_mv - rise2_cyc), 32'd4);

        // Duty change mid-stream
        run_wave(7, 20, 3);

        // Random waveforms
        repeat (12) begin
            p = $urandom_range(40, 4);
            h = $urandom_range(p - 1, 1);
            run_wave(h, p, 2);
        end

        // 2-cycle high glitch inside the low phase of a 3/10 waveform
        run_wave(3, 10, 2);
        repeat (3) drive(1'b1);
        repeat (2) drive(1'b0);
        repeat (2) drive(1'b1);
        repeat (3) drive(1'b0);
        run_wave(3, 10, 2);

        // Stuck low: repeat interval, then recovery
        hold(230);
        check("stuck_lo_interval", 32'(mv_last - mv_prev), 32'(TIMEOUT));
        run_wave(4, 12, 3);

        // Stuck high
        repeat (230) drive(1'b1);
        check("stuck_hi_interval", 32'(mv_last - mv_prev), 32'(TIMEOUT));
        drive(1'b0);
        run_wave(5, 9, 3);

        // Enable dropped during LOW: outputs hold, no publish
        run_wave(3, 10, 3);
        repeat (3) drive(1'b1);
        repeat (6) drive(1'b0);
        en = 1'b0;
        model_clear(1'b0);
        mv_snap = mv_count;
        hold(20);
        check("en_low_no_valid", 32'(mv_count - mv_snap), 32'd0);
        check("en_low_high_held",   32'(high_cnt),   32'd3);
        check("en_low_period_held", 32'(period_cnt), 32'd10);
        check("en_low_valid",       32'(meas_valid), 32'd0);
        en = 1'b1;
        model_clear(1'b0);
        run_wave(3, 10, 4);

        // Asynchronous reset mid-HIGH
        run_wave(7, 20, 2);
        repeat (6) drive(1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("async_rst");
        check("rst_nothing_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        pwm_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear(1'b1);
        hold(4);
        run_wave(6, 15, 3);

        hold(10);
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
